// File: rtl/status_event_reporter.sv
// status_event_reporter
// Watches the upstream status vector, turns each newly-set bit into a 1-based
// index event on a valid/ready stream, buffers events that cannot be issued yet
// in a pending-bit vector, and counts events that collapse into an existing
// pending entry in a saturating merge counter.
//
// Optional feature: define STATUS_EVENT_FALL_EN to also report falling edges
// (adds evt_fall_o and a separate fall-pending vector).
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   status_i         monitored status vector, sampled every cycle
//   evt_val_o        event valid
//   evt_ready_i      consumer ready; handshake when high with evt_val_o
//   evt_idx_o        1-based index of the reported bit
//   evt_fall_o       (STATUS_EVENT_FALL_EN only) 1 for a falling-edge event
//   pending_o        rise events detected but not yet in the output stage
//   merge_cnt_o      saturating count of merged events
//   merge_cnt_clr_i  synchronous clear of merge_cnt_o
module status_event_reporter #(
  parameter int unsigned STATUS_W = 18,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [STATUS_W-1:0] status_i,
  output logic                evt_val_o,
  input  logic                evt_ready_i,
  output logic [IDX_W-1:0]    evt_idx_o,
`ifdef STATUS_EVENT_FALL_EN
  output logic                evt_fall_o,
`endif
  output logic [STATUS_W-1:0] pending_o,
  output logic [CNT_W-1:0]    merge_cnt_o,
  input  logic                merge_cnt_clr_i
);

  // Popcount of up to two STATUS_W vectors needs one bit more than IDX_W.
  localparam int unsigned POP_W = IDX_W + 1;
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Every bit must map onto a non-zero index code.
  if (STATUS_W > (2 ** IDX_W) - 1) begin : g_idx_w_check
    $error("status_event_reporter: STATUS_W does not fit the 1-based IDX_W code space");
  end

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] first_set(input logic [STATUS_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(STATUS_W) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [STATUS_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(STATUS_W); i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] rise_c;
  logic [STATUS_W-1:0] rise_load_c;
  logic [STATUS_W-1:0] rise_merge_c;
  logic [STATUS_W-1:0] pending_next_c;
  logic [IDX_W-1:0]    rise_idx_c;
  logic                rise_any_c;
  logic                load_c;
  logic                sel_fall_c;
  logic [IDX_W-1:0]    sel_idx_c;
  logic [POP_W-1:0]    merge_pop_c;
  logic [SUM_W-1:0]    cnt_sum_c;
  logic [CNT_W-1:0]    cnt_next_c;

`ifdef STATUS_EVENT_FALL_EN
  logic [STATUS_W-1:0] fall_pend_q;
  logic [STATUS_W-1:0] fall_c;
  logic [STATUS_W-1:0] fall_load_c;
  logic [STATUS_W-1:0] fall_merge_c;
  logic [STATUS_W-1:0] fall_next_c;
  logic [IDX_W-1:0]    fall_idx_c;
  logic                fall_any_c;
`endif

  // Edge detection, arbitration and pending/merge bookkeeping.
  always_comb begin
    rise_c     = status_i & ~status_q;
    rise_any_c = |pending_o;
    rise_idx_c = first_set(pending_o);
`ifdef STATUS_EVENT_FALL_EN
    fall_c     = ~status_i & status_q;
    fall_any_c = |fall_pend_q;
    fall_idx_c = first_set(fall_pend_q);
    // Lower index wins; on a tie the rise goes first.
    sel_fall_c = fall_any_c && (!rise_any_c || (fall_idx_c < rise_idx_c));
    load_c     = (!evt_val_o || evt_ready_i) && (rise_any_c || fall_any_c);
`else
    sel_fall_c = 1'b0;
    load_c     = (!evt_val_o || evt_ready_i) && rise_any_c;
`endif
    sel_idx_c = rise_idx_c;
    rise_load_c = '0;
    if (load_c && !sel_fall_c) rise_load_c = STATUS_W'(1) << rise_idx_c;
    // A rise on a bit that stays pending collapses into the existing entry.
    rise_merge_c   = rise_c & pending_o & ~rise_load_c;
    pending_next_c = (pending_o & ~rise_load_c) | rise_c;
    merge_pop_c    = popcount(rise_merge_c);
`ifdef STATUS_EVENT_FALL_EN
    if (sel_fall_c) sel_idx_c = fall_idx_c;
    fall_load_c = '0;
    if (load_c && sel_fall_c) fall_load_c = STATUS_W'(1) << fall_idx_c;
    fall_merge_c = fall_c & fall_pend_q & ~fall_load_c;
    fall_next_c  = (fall_pend_q & ~fall_load_c) | fall_c;
    merge_pop_c  = merge_pop_c + popcount(fall_merge_c);
`endif
    // Clear takes effect before this cycle's increment.
    cnt_sum_c  = SUM_W'(merge_cnt_clr_i ? '0 : merge_cnt_o) + SUM_W'(merge_pop_c);
    cnt_next_c = (cnt_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum_c);
  end

  // State and registered output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q    <= '0;
      pending_o   <= '0;
      evt_val_o   <= 1'b0;
      evt_idx_o   <= '0;
      merge_cnt_o <= '0;
`ifdef STATUS_EVENT_FALL_EN
      fall_pend_q <= '0;
      evt_fall_o  <= 1'b0;
`endif
    end else begin
      status_q    <= status_i;
      pending_o   <= pending_next_c;
      merge_cnt_o <= cnt_next_c;
`ifdef STATUS_EVENT_FALL_EN
      fall_pend_q <= fall_next_c;
`endif
      if (load_c) begin
        evt_val_o <= 1'b1;
        evt_idx_o <= sel_idx_c + IDX_W'(1);
`ifdef STATUS_EVENT_FALL_EN
        evt_fall_o <= sel_fall_c;
`endif
      end else if (evt_ready_i) begin
        evt_val_o <= 1'b0;
      end
    end
  end

endmodule
